// File: rtl/regfile_muldiv_pkg.sv
// Shared definitions for the register file / multiply-divide block: op codes,
// FSM state codes and operand-signedness helpers.
package regfile_muldiv_pkg;

  localparam int unsigned XLEN_DEF = 32;

  // RV32M funct3 encodings
  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  // MDU sequencer states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // rs1 is treated as two's complement for these ops
  function automatic logic op_signed_a(input logic [2:0] op);
    return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  // rs2 is treated as two's complement for these ops
  function automatic logic op_signed_b(input logic [2:0] op);
    return op inside {MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/regfile_muldiv_if.sv
// Core-side bus of the register file: read/write ports, branch flags and the
// multiply/divide launch handshake.
interface regfile_muldiv_if
  import regfile_muldiv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned NREG = 32
);
  localparam int unsigned AW = $clog2(NREG);

  logic            regwen;
  logic [AW-1:0]   rd_addr;
  logic [XLEN-1:0] wr_data;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            breq;
  logic            brlt;
  logic            brltu;
  logic            md_start;
  logic [2:0]      md_op;
  logic            md_busy;
  logic            md_done;
  logic [XLEN-1:0] md_result;

  modport master (
    output regwen, rd_addr, wr_data, rs1_addr, rs2_addr, md_start, md_op,
    input  rs1_data, rs2_data, breq, brlt, brltu, md_busy, md_done, md_result
  );

  modport slave (
    input  regwen, rd_addr, wr_data, rs1_addr, rs2_addr, md_start, md_op,
    output rs1_data, rs2_data, breq, brlt, brltu, md_busy, md_done, md_result
  );

endinterface

// File: rtl/regfile_muldiv_md_iter.sv
// Iterative multiply/divide unit: one shift-add or restoring-divide step per
// cycle on operand magnitudes, sign fix-up on the final step.
module regfile_muldiv_md_iter
  import regfile_muldiv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  localparam int unsigned CW = $clog2(XLEN);

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  // Multiply: {product_hi, multiplier/product_lo}; divide: {remainder, quotient}
  logic [2*XLEN-1:0] acc_q, acc_d, acc_step, prod_fix;
  logic [XLEN-1:0]   b_q, b_d, res_q, res_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;

  logic              sa, sb, ge;
  logic [XLEN-1:0]   ma, mb, hi, lo, trial, q_fix, r_fix;
  logic [XLEN:0]     mul_sum;

  assign hi = acc_q[2*XLEN-1:XLEN];
  assign lo = acc_q[XLEN-1:0];

  // Launch operand signs and magnitudes
  always_comb begin
    sa = op_signed_a(op_i) & a_i[XLEN-1];
    sb = op_signed_b(op_i) & b_i[XLEN-1];
    ma = sa ? -a_i : a_i;
    mb = sb ? -b_i : b_i;
  end

  // One unsigned iteration plus the sign-corrected views of its result
  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
    trial   = {hi[XLEN-2:0], lo[XLEN-1]};
    ge      = {hi, lo[XLEN-1]} >= {1'b0, b_q};
    if (op_q[2]) begin
      acc_step = ge ? {trial - b_q, lo[XLEN-2:0], 1'b1} : {trial, lo[XLEN-2:0], 1'b0};
    end else begin
      acc_step = {mul_sum, lo[XLEN-1:1]};
    end
    prod_fix = neg_q ? -acc_step : acc_step;
    q_fix    = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    r_fix    = neg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
  end

  // Sequencer: IDLE -> CALC (XLEN steps) -> DONE -> IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    b_d     = b_q;
    op_d    = op_q;
    neg_d   = neg_q;
    res_d   = res_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_CALC;
          cnt_d   = '0;
          op_d    = op_i;
          if (op_i[2]) begin
            acc_d = {{XLEN{1'b0}}, ma};
            b_d   = mb;
            // Divide by zero keeps the all-ones quotient; remainder follows the dividend
            neg_d = op_i[1] ? sa : ((sa ^ sb) & (b_i != '0));
          end else begin
            acc_d = {{XLEN{1'b0}}, mb};
            b_d   = ma;
            neg_d = sa ^ sb;
          end
        end
      end
      ST_CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN - 1)) begin
          state_d = ST_DONE;
          unique case (op_q)
            MD_MUL:                      res_d = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: res_d = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:             res_d = q_fix;
            default:                     res_d = r_fix;
          endcase
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
    end
  end

  assign busy_o   = (state_q != ST_IDLE);
  assign done_o   = (state_q == ST_DONE);
  assign result_o = res_q;

endmodule

// File: rtl/regfile_muldiv.sv
// Register file with write-through bypass, branch comparators and an attached
// iterative MDU whose results are written back automatically.
module regfile_muldiv
  import regfile_muldiv_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned NREG   = 32,
  parameter bit          BYPASS = 1'b1
) (
  input logic              clk,
  input logic              rst,
  regfile_muldiv_if.slave  bus
);
  localparam int unsigned AW = $clog2(NREG);

  logic [XLEN-1:0] regs_q [NREG];
  logic [AW-1:0]   rd_q;
  logic            md_busy, md_done, launch, wb_en, we;
  logic [XLEN-1:0] md_result, wdata, rs1_val, rs2_val;
  logic [AW-1:0]   waddr;

  assign launch = bus.md_start & ~md_busy;
  assign wb_en  = md_done & (rd_q != '0);

  regfile_muldiv_md_iter #(
    .XLEN(XLEN)
  ) u_md_iter (
    .clk     (clk),
    .rst     (rst),
    .start_i (bus.md_start),
    .op_i    (bus.md_op),
    .a_i     (rs1_val),
    .b_i     (rs2_val),
    .busy_o  (md_busy),
    .done_o  (md_done),
    .result_o(md_result)
  );

  // Write port arbitration: MDU writeback beats the external write
  always_comb begin
    we    = 1'b0;
    waddr = bus.rd_addr;
    wdata = bus.wr_data;
    if (wb_en) begin
      we    = 1'b1;
      waddr = rd_q;
      wdata = md_result;
    end else if (bus.regwen && (bus.rd_addr != '0)) begin
      we = 1'b1;
    end
  end

  // Asynchronous reads with optional write-through; x0 is hardwired to zero
  always_comb begin
    rs1_val = regs_q[bus.rs1_addr];
    rs2_val = regs_q[bus.rs2_addr];
    if (BYPASS && we && (waddr == bus.rs1_addr)) rs1_val = wdata;
    if (BYPASS && we && (waddr == bus.rs2_addr)) rs2_val = wdata;
    if (bus.rs1_addr == '0) rs1_val = '0;
    if (bus.rs2_addr == '0) rs2_val = '0;
  end

  // Register array
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  // Destination of the in-flight MDU op
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
    end else if (launch) begin
      rd_q <= bus.rd_addr;
    end
  end

  assign bus.rs1_data  = rs1_val;
  assign bus.rs2_data  = rs2_val;
  assign bus.breq      = (rs1_val == rs2_val);
  assign bus.brlt      = ($signed(rs1_val) < $signed(rs2_val));
  assign bus.brltu     = (rs1_val < rs2_val);
  assign bus.md_busy   = md_busy;
  assign bus.md_done   = md_done;
  assign bus.md_result = md_result;

endmodule

// File: tb/tb_regfile_muldiv.sv
// Scoreboard bench: each MDU launch queues its expected result; a monitor
// compares md_result and launch-to-done latency on every md_done pulse.
module tb_regfile_muldiv;
  import regfile_muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   launch_cyc = 0;
  int   npass = 0;
  int   ntotal = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  regfile_muldiv_if #(.XLEN(32), .NREG(32)) bus ();

  regfile_muldiv #(
    .XLEN  (32),
    .NREG  (32),
    .BYPASS(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
  endtask

  // Monitor: pop and compare on every md_done pulse
  logic [31:0] mon_exp;
  string       mon_nm;
  always @(negedge clk) begin
    if (bus.md_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        ntotal++;
        $display("FAIL unexpected_done: got md_done=1 at cycle %0d, want no pulse", cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_nm  = name_q.pop_front();
        chk(mon_nm, bus.md_result, mon_exp);
        chk({mon_nm, "_latency"}, 32'(cyc - launch_cyc + 1), 32'd33);
      end
    end
  end

  task automatic wr(input logic [4:0] idx, input logic [31:0] val);
    @(posedge clk); #1;
    bus.regwen = 1'b1; bus.rd_addr = idx; bus.wr_data = val;
    @(posedge clk); #1;
    bus.regwen = 1'b0;
  endtask

  task automatic rd_reg(input string nm, input logic [4:0] idx, input logic [31:0] exp);
    bus.rs1_addr = idx;
    #1;
    chk(nm, bus.rs1_data, exp);
  endtask

  task automatic md_go(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] exp, input string nm,
                       input bit push);
    @(posedge clk); #1;
    if (push) begin
      exp_q.push_back(exp);
      name_q.push_back(nm);
    end
    bus.md_op = op; bus.rd_addr = rd; bus.rs1_addr = rs1; bus.rs2_addr = rs2;
    bus.md_start = 1'b1;
    @(posedge clk); #1;
    bus.md_start = 1'b0;
    launch_cyc = cyc;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (bus.md_busy && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.md_busy) begin
      ntotal++;
      $display("FAIL %s_timeout: md_busy still 1 after %0d cycles, want 0", nm, n);
    end
  endtask

  task automatic md_run(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] exp, input string nm);
    md_go(op, rd, rs1, rs2, exp, nm, 1'b1);
    wait_idle(nm);
    rd_reg({nm, "_wb"}, rd, (rd == 5'd0) ? 32'd0 : exp);
  endtask

  initial begin
    int n;
    bus.regwen = 1'b0; bus.rd_addr = '0; bus.wr_data = '0;
    bus.rs1_addr = '0; bus.rs2_addr = '0; bus.md_start = 1'b0; bus.md_op = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_busy", 32'(bus.md_busy), 32'd0);
    chk("rst_done", 32'(bus.md_done), 32'd0);
    chk("rst_result", bus.md_result, 32'd0);
    rd_reg("rst_x5", 5'd5, 32'd0);

    // Writes, reads and branch flags
    wr(5'd5, 32'd7);
    wr(5'd6, 32'hFFFF_FFFD);
    rd_reg("x5", 5'd5, 32'd7);
    bus.rs2_addr = 5'd6; #1;
    chk("x6_rs2", bus.rs2_data, 32'hFFFF_FFFD);
    chk("flags_7_m3", {29'd0, bus.breq, bus.brlt, bus.brltu}, 32'b001);
    bus.rs2_addr = 5'd5; #1;
    chk("flags_eq", {29'd0, bus.breq, bus.brlt, bus.brltu}, 32'b100);

    // Multiply
    md_go(MD_MUL, 5'd7, 5'd5, 5'd6, 32'hFFFF_FFEB, "mul_7_m3", 1'b1);
    chk("busy_after_launch", 32'(bus.md_busy), 32'd1);
    wait_idle("mul_7_m3");
    rd_reg("mul_7_m3_wb", 5'd7, 32'hFFFF_FFEB);
    md_run(MD_MULH, 5'd8, 5'd5, 5'd6, 32'hFFFF_FFFF, "mulh_7_m3");
    wr(5'd1, 32'h8000_0000);
    wr(5'd2, 32'h8000_0000);
    md_run(MD_MULH, 5'd10, 5'd1, 5'd2, 32'h4000_0000, "mulh_min");
    md_run(MD_MULHU, 5'd10, 5'd1, 5'd2, 32'h4000_0000, "mulhu_min");
    md_run(MD_MULHSU, 5'd10, 5'd1, 5'd2, 32'hC000_0000, "mulhsu_min");
    md_run(MD_MUL, 5'd10, 5'd1, 5'd2, 32'h0000_0000, "mul_min");

    // Divide / remainder
    wr(5'd3, 32'd100);
    wr(5'd4, 32'd7);
    md_run(MD_DIVU, 5'd10, 5'd3, 5'd4, 32'd14, "divu_100_7");
    md_run(MD_REMU, 5'd10, 5'd3, 5'd4, 32'd2, "remu_100_7");
    wr(5'd11, 32'hFFFF_FFF9);
    wr(5'd12, 32'd2);
    bus.rs1_addr = 5'd11; bus.rs2_addr = 5'd12; #1;
    chk("flags_m7_2", {29'd0, bus.breq, bus.brlt, bus.brltu}, 32'b010);
    md_run(MD_DIV, 5'd10, 5'd11, 5'd12, 32'hFFFF_FFFD, "div_m7_2");
    md_run(MD_REM, 5'd10, 5'd11, 5'd12, 32'hFFFF_FFFF, "rem_m7_2");

    // Divisor zero (x0) and signed overflow
    wr(5'd13, 32'd5);
    md_run(MD_DIV, 5'd10, 5'd13, 5'd0, 32'hFFFF_FFFF, "div_5_0");
    md_run(MD_REMU, 5'd10, 5'd13, 5'd0, 32'd5, "remu_5_0");
    md_run(MD_DIV, 5'd10, 5'd11, 5'd0, 32'hFFFF_FFFF, "div_m7_0");
    md_run(MD_REM, 5'd10, 5'd11, 5'd0, 32'hFFFF_FFF9, "rem_m7_0");
    wr(5'd14, 32'hFFFF_FFFF);
    md_run(MD_DIV, 5'd10, 5'd1, 5'd14, 32'h8000_0000, "div_ovf");
    md_run(MD_REM, 5'd10, 5'd1, 5'd14, 32'h0000_0000, "rem_ovf");

    // md_start while busy is ignored
    md_go(MD_MUL, 5'd15, 5'd5, 5'd5, 32'd49, "mul_ign", 1'b1);
    repeat (3) @(posedge clk);
    #1 bus.md_op = MD_DIVU; bus.rd_addr = 5'd20; bus.md_start = 1'b1;
    @(posedge clk); #1 bus.md_start = 1'b0;
    wait_idle("mul_ign");
    repeat (40) @(posedge clk);
    #1;
    rd_reg("mul_ign_wb", 5'd15, 32'd49);
    rd_reg("ign_x20", 5'd20, 32'd0);

    // Result to x0 is discarded
    md_run(MD_MUL, 5'd0, 5'd5, 5'd5, 32'd49, "mul_x0");

    // Same-cycle write and read with bypass
    @(posedge clk); #1;
    bus.regwen = 1'b1; bus.rd_addr = 5'd16; bus.wr_data = 32'h0000_1234; bus.rs1_addr = 5'd16;
    #1 chk("bypass_same_cycle", bus.rs1_data, 32'h0000_1234);
    @(posedge clk); #1 bus.regwen = 1'b0;
    rd_reg("bypass_after", 5'd16, 32'h0000_1234);

    // regwen collides with MDU writeback to x9
    md_go(MD_MUL, 5'd9, 5'd5, 5'd6, 32'hFFFF_FFEB, "mul_x9", 1'b1);
    n = 0;
    while (!bus.md_done && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.md_done) begin
      ntotal++;
      $display("FAIL collide_timeout: md_done=0 after %0d cycles, want 1", n);
    end
    bus.regwen = 1'b1; bus.rd_addr = 5'd9; bus.wr_data = 32'h0000_DEAD; bus.rs1_addr = 5'd9;
    #1 chk("collide_bypass", bus.rs1_data, 32'hFFFF_FFEB);
    @(posedge clk); #1 bus.regwen = 1'b0;
    rd_reg("collide_x9", 5'd9, 32'hFFFF_FFEB);

    // Reset in the middle of CALC
    md_go(MD_MUL, 5'd17, 5'd5, 5'd5, 32'd0, "mul_rst", 1'b0);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", 32'(bus.md_busy), 32'd0);
    chk("midrst_done", 32'(bus.md_done), 32'd0);
    chk("midrst_result", bus.md_result, 32'd0);
    rst = 1'b0;
    rd_reg("midrst_x5", 5'd5, 32'd0);
    rd_reg("midrst_x7", 5'd7, 32'd0);
    rd_reg("midrst_x17", 5'd17, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    wr(5'd5, 32'd7);
    wr(5'd6, 32'hFFFF_FFFD);
    md_run(MD_MUL, 5'd7, 5'd5, 5'd6, 32'hFFFF_FFEB, "mul_after_rst");

    repeat (5) @(posedge clk);
    #1 chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
